// File: rtl/data_bus_pkg.sv
// Shared types for the data-side bus arbiter: FSM states, length codes and the latched request.
// Package only; no timing or flow-control behaviour of its own.
package data_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    localparam int WS_W = 4;

    typedef struct packed {
        logic        rw;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    // Writes and faulting accesses return zero so stale bus data never leaks out.
    function automatic logic [31:0] resp_data(input logic rw, input logic exc, input logic [31:0] rd);
        return (rw || exc) ? 32'd0 : rd;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one that did not win last.
// Purely combinational, zero latency; no backpressure of its own.
// Stateless so the instruction side can reuse it with its own `last` register.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares data_bus between m0 (load/store) and m1 (debug/DMA); round-robin, one access at a time.
// Latency: gnt at t, bus t+1..t+1+WAIT_STATES, rvalid pulse at t+2+WAIT_STATES.
// Backpressure: requests simply wait (gnt low) while an access is in BUS or RESP.
module data_bus_arbiter
    import data_bus_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [1:0]  m0_len,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_exc,

    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [1:0]  m1_len,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_exc,

    output logic        bus_rw,
    output logic [1:0]  bus_len,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write,
    input  logic [31:0] bus_read,
    input  logic        bus_exception
);

    state_t           state;
    logic             last;
    logic             owner;
    logic [WS_W-1:0]  cnt;
    bus_req_t         cur;
    logic [1:0]       resp_vld;
    logic [31:0]      resp_rdata;
    logic             resp_exc;
    logic [1:0]       win;
    logic             idle;

    rr_arbiter2 u_arb (
        .req   ({m1_req, m0_req}),
        .last  (last),
        .grant (win)
    );

    assign idle   = (state == ST_IDLE);
    assign m0_gnt = idle & win[0];
    assign m1_gnt = idle & win[1];

    // cur is only non-zero while in BUS, so the bus pins come straight off flops.
    assign bus_rw    = cur.rw;
    assign bus_len   = cur.len;
    assign bus_addr  = cur.addr;
    assign bus_write = cur.wdata;

    assign m0_rvalid = resp_vld[0];
    assign m1_rvalid = resp_vld[1];
    assign m0_rdata  = resp_vld[0] ? resp_rdata : 32'd0;
    assign m1_rdata  = resp_vld[1] ? resp_rdata : 32'd0;
    assign m0_exc    = resp_vld[0] & resp_exc;
    assign m1_exc    = resp_vld[1] & resp_exc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last       <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            cur        <= '0;
            resp_vld   <= 2'b00;
            resp_rdata <= 32'd0;
            resp_exc   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win != 2'b00) begin
                        owner <= win[1];
                        last  <= win[1];
                        cnt   <= WS_W'(WAIT_STATES);
                        if (win[1]) begin
                            cur <= '{rw: m1_rw, len: m1_len, addr: m1_addr, wdata: m1_wdata};
                        end else begin
                            cur <= '{rw: m0_rw, len: m0_len, addr: m0_addr, wdata: m0_wdata};
                        end
                        state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (cnt == '0) begin
                        resp_rdata <= resp_data(cur.rw, bus_exception, bus_read);
                        resp_exc   <= bus_exception;
                        resp_vld   <= owner ? 2'b10 : 2'b01;
                        cur        <= '0;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - WS_W'(1);
                    end
                end
                ST_RESP: begin
                    resp_vld <= 2'b00;
                    state    <= ST_IDLE;
                end
                default: begin
                    resp_vld <= 2'b00;
                    cur      <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed and randomized checks of data_bus_arbiter against a transaction-level reference model.
// A WAIT_STATES=0 instance is exercised at the end for latency and grant spacing.
module tb_data_bus_arbiter;
    import data_bus_pkg::*;

    localparam int          WS       = 1;
    localparam logic [31:0] LED_ADDR = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 0, m0_rw = 0, m1_req = 0, m1_rw = 0;
    logic [1:0]  m0_len = 0, m1_len = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_exc, m1_gnt, m1_rvalid, m1_exc;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_rw, bus_exception;
    logic [1:0]  bus_len;
    logic [31:0] bus_addr, bus_write, bus_read;
    logic [7:0]  led;

    logic        z_m0_req = 0;
    logic [31:0] z_m0_addr = 32'h1000;
    logic        z_m0_gnt, z_m0_rvalid, z_m0_exc, z_m1_gnt, z_m1_rvalid, z_m1_exc;
    logic [31:0] z_m0_rdata, z_m1_rdata;
    logic        z_bus_rw;
    logic [1:0]  z_bus_len;
    logic [31:0] z_bus_addr, z_bus_write;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h1000) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    assign bus_read      = mem_rd(bus_addr);
    assign bus_exception = (bus_addr[31:28] == 4'hE);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) led <= 8'h00;
        else if (bus_rw && bus_addr == LED_ADDR) led <= bus_write[7:0];
    end

    data_bus_arbiter #(.WAIT_STATES(WS)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_len(m0_len), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_exc(m0_exc),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_len(m1_len), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_exc(m1_exc),
        .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr), .bus_write(bus_write),
        .bus_read(bus_read), .bus_exception(bus_exception)
    );

    data_bus_arbiter #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(z_m0_req), .m0_rw(1'b0), .m0_len(LEN_WORD), .m0_addr(z_m0_addr), .m0_wdata(32'd0),
        .m0_gnt(z_m0_gnt), .m0_rvalid(z_m0_rvalid), .m0_rdata(z_m0_rdata), .m0_exc(z_m0_exc),
        .m1_req(1'b0), .m1_rw(1'b0), .m1_len(2'd0), .m1_addr(32'd0), .m1_wdata(32'd0),
        .m1_gnt(z_m1_gnt), .m1_rvalid(z_m1_rvalid), .m1_rdata(z_m1_rdata), .m1_exc(z_m1_exc),
        .bus_rw(z_bus_rw), .bus_len(z_bus_len), .bus_addr(z_bus_addr), .bus_write(z_bus_write),
        .bus_read(mem_rd(z_bus_addr)), .bus_exception(z_bus_addr[31:28] == 4'hE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: at most one transaction in flight, described by its grant cycle and fields.
    bit          mon_en = 0;
    bit          inf_v = 0;
    int          inf_cyc, inf_owner, n_grants = 0;
    bit          last_win = 1;
    logic        inf_rw;
    logic [1:0]  inf_len;
    logic [31:0] inf_addr, inf_wdata;

    always @(negedge clk) begin
        if (mon_en) begin
            int   rel, w;
            logic exc_e;
            if (inf_v) begin
                rel = cyc - inf_cyc;
                check("busy_no_gnt", {m1_gnt, m0_gnt}, 0);
                if (rel >= 1 && rel <= WS + 1) begin
                    check("bus_rw", bus_rw, inf_rw);
                    check("bus_len", bus_len, inf_len);
                    check("bus_addr", bus_addr, inf_addr);
                    check("bus_write", bus_write, inf_wdata);
                end else begin
                    check("bus_idle_rw", bus_rw, 0);
                    check("bus_idle_addr", bus_addr, 0);
                end
                if (rel == WS + 2) begin
                    exc_e = (inf_addr[31:28] == 4'hE);
                    check("rvalid_owner", {m1_rvalid, m0_rvalid}, inf_owner ? 2 : 1);
                    check("resp_exc", inf_owner ? m1_exc : m0_exc, exc_e);
                    check("resp_rdata", inf_owner ? m1_rdata : m0_rdata,
                          (inf_rw || exc_e) ? 32'd0 : mem_rd(inf_addr));
                    inf_v = 0;
                end else begin
                    check("rvalid_quiet", {m1_rvalid, m0_rvalid}, 0);
                end
            end else begin
                check("idle_bus_rw", bus_rw, 0);
                check("idle_bus_addr", bus_addr, 0);
                check("idle_bus_wl", bus_write | 32'(bus_len), 0);
                check("idle_rvalid", {m1_rvalid, m0_rvalid}, 0);
                if (m0_req && m1_req) w = last_win ? 0 : 1;
                else if (m0_req)      w = 0;
                else if (m1_req)      w = 1;
                else                  w = -1;
                check("gnt", {m1_gnt, m0_gnt}, (w < 0) ? 0 : ((w == 0) ? 1 : 2));
                if (w >= 0) begin
                    inf_v     = 1;
                    inf_cyc   = cyc;
                    inf_owner = w;
                    inf_rw    = w ? m1_rw : m0_rw;
                    inf_len   = w ? m1_len : m0_len;
                    inf_addr  = w ? m1_addr : m0_addr;
                    inf_wdata = w ? m1_wdata : m0_wdata;
                    last_win  = w[0];
                    n_grants++;
                end
            end
        end
    end

    task automatic do_reset();
        mon_en  = 0;
        m0_req  = 0;
        m1_req  = 0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        inf_v    = 0;
        last_win = 1;
        mon_en   = 1;
    endtask

    task automatic wait_gnt(output int w);
        w = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                w = m1_gnt ? 1 : 0;
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h1000;
            1:       return 32'hE000_0000 | ($urandom & 32'hFFFC);
            2:       return LED_ADDR;
            default: return $urandom & 32'h0000_FFFC;
        endcase
    endfunction

    initial begin
        int w, cnt_a, cnt_b, lat, sp;
        logic g0, g1;
        int gq[$], rq[$];
        logic [31:0] z_rd;

        // Reset state
        #3;
        check("rst_gnt", {m1_gnt, m0_gnt}, 0);
        check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        check("rst_rdata", m0_rdata | m1_rdata, 0);
        check("rst_bus", {31'd0, bus_rw} | bus_addr | bus_write | 32'(bus_len), 0);
        do_reset();

        // Single m0 read of the RAM word
        m0_rw = 0; m0_len = LEN_WORD; m0_addr = 32'h1000; m0_req = 1;
        @(negedge clk);
        check("t1_m0_gnt", m0_gnt, 1);
        check("t1_m1_gnt", m1_gnt, 0);
        @(posedge clk); #1 m0_req = 0;
        @(negedge clk);
        check("t1_bus_rw_a", bus_rw, 0);
        check("t1_bus_addr_a", bus_addr, 32'h1000);
        @(negedge clk);
        check("t1_bus_addr_b", bus_addr, 32'h1000);
        @(negedge clk);
        check("t1_rvalid", m0_rvalid, 1);
        check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t1_exc", m0_exc, 0);
        check("t1_m1_quiet", {m1_rvalid, m1_gnt}, 0);
        @(negedge clk);
        check("t1_rvalid_pulse", m0_rvalid, 0);

        // Both requesting from reset: strict alternation
        do_reset();
        m0_addr = 32'h100; m1_addr = 32'h200; m0_rw = 0; m1_rw = 0;
        m0_req = 1; m1_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(w);
            check("rr_order", w, k % 2);
        end
        @(posedge clk); #1 m0_req = 0; m1_req = 0;
        repeat (6) @(negedge clk);

        // m1 write to the LED register
        @(posedge clk); #1;
        m1_rw = 1; m1_len = LEN_BYTE; m1_addr = LED_ADDR; m1_wdata = 32'h0000_00A5; m1_req = 1;
        wait_gnt(w);
        check("led_gnt", w, 1);
        @(posedge clk); #1 m1_req = 0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_rw) cnt_a++;
            if (m1_rvalid) begin
                cnt_b++;
                check("led_rdata", m1_rdata, 0);
            end
        end
        check("led_rw_cycles", cnt_a, WS + 1);
        check("led_rvalid_cnt", cnt_b, 1);
        check("led_value", led, 8'hA5);

        // m0 read that faults
        @(posedge clk); #1;
        m0_rw = 0; m0_addr = 32'hE000_0010; m0_req = 1;
        wait_gnt(w);
        check("exc_gnt", w, 0);
        @(posedge clk); #1 m0_req = 0;
        repeat (3) @(negedge clk);
        check("exc_rvalid", m0_rvalid, 1);
        check("exc_flag", m0_exc, 1);
        check("exc_rdata", m0_rdata, 0);
        @(negedge clk);

        // Reset in the middle of an m0 write: abandoned, and m0 still wins the next tie
        @(posedge clk); #1;
        m0_rw = 1; m0_addr = LED_ADDR; m0_wdata = 32'h3C; m0_req = 1;
        wait_gnt(w);
        check("abort_gnt", w, 0);
        @(posedge clk); #1 m0_req = 0;
        #2;
        mon_en = 0; reset_n = 0;
        #1;
        check("abort_bus_rw", bus_rw, 0);
        check("abort_bus_addr", bus_addr | bus_write, 0);
        check("abort_rvalid", {m1_rvalid, m0_rvalid}, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        inf_v = 0; last_win = 1; mon_en = 1;
        cnt_a = 0;
        repeat (5) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid) cnt_a++;
        end
        check("abort_no_rvalid", cnt_a, 0);
        @(posedge clk); #1;
        m0_rw = 0; m1_rw = 0; m0_addr = 32'h300; m1_addr = 32'h400;
        m0_req = 1; m1_req = 1;
        wait_gnt(w);
        check("abort_first_gnt", w, 0);
        @(posedge clk); #1 m0_req = 0; m1_req = 0;
        repeat (6) @(negedge clk);

        // Randomized traffic against the reference model
        do_reset();
        n_grants = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
            @(posedge clk); #1;
            if (!m0_req || g0) begin
                m0_req = ($urandom_range(0, 3) != 0);
                m0_rw = 1'($urandom); m0_len = 2'($urandom);
                m0_addr = pick_addr(); m0_wdata = $urandom;
            end
            if (!m1_req || g1) begin
                m1_req = ($urandom_range(0, 3) != 0);
                m1_rw = 1'($urandom); m1_len = 2'($urandom);
                m1_addr = pick_addr(); m1_wdata = $urandom;
            end
        end
        m0_req = 0; m1_req = 0;
        repeat (6) @(negedge clk);
        check("rand_grants_seen", n_grants > 50, 1);

        // WAIT_STATES=0 instance: latency 2, back-to-back grants every 3 cycles
        @(posedge clk); #1 z_m0_req = 1;
        z_rd = 32'hFFFF_FFFF;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (z_m0_gnt) gq.push_back(cyc);
            if (z_m0_rvalid) begin
                if (rq.size() == 0) z_rd = z_m0_rdata;
                rq.push_back(cyc);
            end
        end
        z_m0_req = 0;
        lat = (gq.size() > 0 && rq.size() > 0) ? rq[0] - gq[0] : -1;
        sp  = (gq.size() > 1) ? gq[1] - gq[0] : -1;
        check("ws0_latency", lat, 2);
        check("ws0_spacing", sp, 3);
        check("ws0_rdata", z_rd, 32'hDEAD_BEEF);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single combinational data_bus between two requesters: m0 is the core load/store unit, m1 is the debug/DMA port.
- Grants one requester at a time using round-robin, and sequences each access through a fixed number of bus cycles (wait states for slow RAM).
- Registers the read data and exception, then returns them as a one-cycle response pulse.
- Drives the bus idle (rw=0) between accesses so the LED write-decode in data_bus never sees spurious writes.

Parameters:
- WAIT_STATES, 1, extra bus cycles per access (0..15); an access holds the bus for WAIT_STATES+1 cycles.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  m0 access request (level)
- m0_rw  in  1  1=write, 0=read
- m0_len  in  2  access length code, passed to bus unchanged
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_gnt  out  1  request accepted this cycle
- m0_rvalid  out  1  response valid, one-cycle pulse
- m0_rdata  out  32  read data (valid with m0_rvalid)
- m0_exc  out  1  access exception (valid with m0_rvalid)
- m1_req, m1_rw, m1_len, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_exc: same as m0
- bus_rw  out  1  to data_bus rw
- bus_len  out  2  to data_bus len
- bus_addr  out  32  to data_bus addr
- bus_write  out  32  to data_bus write
- bus_read  in  32  from data_bus read
- bus_exception  in  1  from data_bus exception

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, last=1 (so m0 wins the first tie), wait counter=0.
  - All outputs 0; bus_* outputs 0.
- States: IDLE, BUS, RESP.
- IDLE:
  - Only m0_req set -> grant m0. Only m1_req set -> grant m1.
  - Both set -> grant the master that is not `last`.
  - mX_gnt is combinational: high in IDLE while that master wins.
  - At the edge with a grant: latch rw/len/addr/wdata and the owner; set last=owner; load counter=WAIT_STATES; go to BUS.
- BUS:
  - bus_rw/len/addr/write are driven from the latched request, for exactly WAIT_STATES+1 cycles.
  - The counter decrements each cycle.
  - At the edge where counter==0: capture bus_read and bus_exception; go to RESP.
- RESP:
  - Owner's rvalid=1 for exactly one cycle; then go to IDLE. The non-owner's rvalid stays 0.
  - rdata = captured read for reads. rdata = 0 for writes, and 0 whenever exc=1.
  - The exception is reported for reads and writes alike.
- Outside BUS:
  - bus_rw=0, bus_len=0, bus_addr=0, bus_write=0 (no glitches toward the LED register).
- Latency:
  - gnt at cycle t; bus active t+1 .. t+1+WAIT_STATES; rvalid at t+2+WAIT_STATES.
  - Next grant no earlier than the cycle after rvalid.
- Requester rules:
  - Hold req and its fields stable until gnt; fields may change after gnt.
  - A req still high after gnt is a new request.
  - No grant is given in BUS or RESP; requests wait.
- Fairness: with both requesting continuously, grants strictly alternate.
- Reset mid-access: abandon immediately; no rvalid is ever issued for the abandoned access.
- No timeouts; the bus always completes in the fixed cycle count.

Decomposition:
- Shared package data_bus_pkg:
  - state encoding (IDLE/BUS/RESP)
  - length codes (byte/half/word)
  - WAIT_STATES counter width (4)
  - existing address token/range macros stay with data_bus
- One sub-module, rr_arbiter2: inputs req[1:0], last; outputs one-hot grant. Purely combinational, and reusable for the instruction side.

Test Plan:
- WAIT_STATES=1; m0 read addr 0x0000_1000 with RAM word 0xDEADBEEF:
  - m0_gnt at t, bus_rw=0 at t+1..t+2, m0_rvalid at t+3 with rdata=0xDEADBEEF, exc=0; m1 signals stay 0.
- m0 and m1 both requesting from reset:
  - grants in order m0, m1, m0, m1; bus_addr matches the owner each time; no overlapping rvalids.
- m1 write 0x0000_00A5 to the LEDS address:
  - bus_rw=1 only during the BUS cycles; led=0xA5 after the access; m1_rvalid with rdata=0.
  - bus_rw=0 before and after the access.
- m0 read of an address producing bus_exception=1:
  - m0_rvalid with m0_exc=1, m0_rdata=0.
- reset_n pulsed low during BUS:
  - all outputs 0 immediately; no rvalid; the next request after release is granted to m0 first.
- WAIT_STATES=0 build:
  - gnt→rvalid latency is 2 cycles; back-to-back m0 requests are granted every 3 cycles.
